// File: rtl/id_rf_read_unit_pkg.sv
// Shared constants and init-sweep state type for the ID-stage register-file read unit.
package id_rf_read_unit_pkg;

   localparam int RV_ADR_W  = 5;
   localparam int RV_NREG_I = 32;
   localparam int RV_NREG_E = 16;

   // Init sweep starts at x1; x0 is never stored.
   localparam int RF_CLR_IDX_START = 1;

   typedef enum logic {
      S_CLR = 1'b0,
      S_RUN = 1'b1
   } rf_init_e;

endpackage

// File: rtl/id_rf_read_unit_rf_nr1w.sv
// Register-file storage: NRP asynchronous read ports, one write port, and a clear port.
// Storage only; zero, bypass and hold handling live in the parent.
module rf_nr1w #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRP  = 2,
   parameter int IW   = $clog2(NREG)
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [IW-1:0]            wadr_i,
   input  logic [XLEN-1:0]          wdata_i,
   input  logic                     clr_en_i,
   input  logic [IW-1:0]            clr_adr_i,
   input  logic [NRP-1:0][IW-1:0]   radr_i,
   output logic [NRP-1:0][XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] mem [NREG];

   // The real write is ordered last so it wins over a clear of the same entry.
   always_ff @(posedge clk) begin
      if (clr_en_i) mem[clr_adr_i] <= '0;
      if (we_i)     mem[wadr_i]    <= wdata_i;
   end

   for (genvar p = 0; p < NRP; p++) begin : g_rd
      assign rdata_o[p] = mem[radr_i[p]];
   end

endmodule

// File: rtl/id_rf_read_unit.sv
// ID-stage register-file read unit with registered, stall-holding operands to EX.
// Optional init sweep of the array after reset is enabled by defining RF_CLEAR_EN.
module id_rf_read_unit
   import id_rf_read_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = RV_NREG_I,
   parameter int NRP   = 2,
   parameter int ADR_W = RV_ADR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rst_pipe,
   input  logic                  stall,
   input  logic [NRP*ADR_W-1:0]  rs_adr_id,
   input  logic [NRP-1:0]        rs_en_id,
   output logic [NRP*XLEN-1:0]   rs_data_ex,
   output logic                  rs_ill_ex,
   input  logic [ADR_W-1:0]      rd_adr_wb,
   input  logic                  wbk_rd_reg_wb,
   input  logic [XLEN-1:0]       wbk_data_wb,
   output logic                  rf_busy
);

   localparam int             IW     = $clog2(NREG);
   localparam logic [ADR_W:0] NREG_L = (ADR_W+1)'(NREG);

   logic                          wb_vld;
   logic [NRP-1:0][ADR_W-1:0]     adr;
   logic [NRP-1:0][IW-1:0]        ridx;
   logic [NRP-1:0]                oob;
   logic [NRP-1:0][XLEN-1:0]      rdata;
   logic [NRP-1:0][XLEN-1:0]      data_q, data_d;
   logic [NRP-1:0][ADR_W-1:0]     held_adr_q, held_adr_d;
   logic                          ill_q, ill_d;
   logic                          clr_en;
   logic [IW-1:0]                 clr_adr;

   assign wb_vld = wbk_rd_reg_wb && (rd_adr_wb != '0) && ({1'b0, rd_adr_wb} < NREG_L);

   rf_nr1w #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NRP  (NRP),
      .IW   (IW)
   ) u_rf (
      .clk       (clk),
      .we_i      (wb_vld),
      .wadr_i    (rd_adr_wb[IW-1:0]),
      .wdata_i   (wbk_data_wb),
      .clr_en_i  (clr_en),
      .clr_adr_i (clr_adr),
      .radr_i    (ridx),
      .rdata_o   (rdata)
   );

   for (genvar p = 0; p < NRP; p++) begin : g_port
      assign adr[p]  = rs_adr_id[p*ADR_W +: ADR_W];
      assign oob[p]  = {1'b0, adr[p]} >= NREG_L;
      assign ridx[p] = adr[p][IW-1:0];

      always_comb begin
         data_d[p]     = data_q[p];
         held_adr_d[p] = held_adr_q[p];
         if (rst_pipe) begin
            data_d[p]     = '0;
            held_adr_d[p] = '0;
         end else if (!stall) begin
            held_adr_d[p] = adr[p];
            if ((adr[p] == '0) || oob[p] || !rs_en_id[p])
               data_d[p] = '0;
            else if (wb_vld && (rd_adr_wb == adr[p]))
               data_d[p] = wbk_data_wb;
            else
               data_d[p] = rdata[p];
         end else if ((held_adr_q[p] != '0) && wb_vld && (rd_adr_wb == held_adr_q[p])) begin
            // A write landing on a held operand refreshes it so EX never sees a stale value.
            data_d[p] = wbk_data_wb;
         end
      end
   end

   always_comb begin
      ill_d = ill_q;
      if (rst_pipe)    ill_d = 1'b0;
      else if (!stall) ill_d = |(rs_en_id & oob);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         held_adr_q <= '0;
         ill_q      <= 1'b0;
      end else begin
         data_q     <= data_d;
         held_adr_q <= held_adr_d;
         ill_q      <= ill_d;
      end
   end

   assign rs_data_ex = data_q;
   assign rs_ill_ex  = ill_q;

`ifdef RF_CLEAR_EN
   rf_init_e      state_q;
   logic [IW-1:0] idx_q;
   logic          busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_CLR;
         idx_q   <= IW'(RF_CLR_IDX_START);
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            S_CLR: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == IW'(NREG-1)) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_RUN;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en  = (state_q == S_CLR);
   assign clr_adr = idx_q;
   assign rf_busy = busy_q;
`else
   assign clr_en  = 1'b0;
   assign clr_adr = '0;
   assign rf_busy = 1'b0;
`endif

endmodule

// File: tb/tb_id_rf_read_unit.sv
// Directed scoreboard bench for id_rf_read_unit; runs an RV32I and an RV32E instance side by side.
module tb_id_rf_read_unit;

   logic        clk = 1'b0;
   logic        rst_n, rst_pipe, stall;
   logic [9:0]  rs_adr_id;
   logic [1:0]  rs_en_id;
   logic [4:0]  rd_adr_wb;
   logic        wbk_rd_reg_wb;
   logic [31:0] wbk_data_wb;
   logic [63:0] d32, d16;
   logic        i32, i16, b32, b16;

   int nasrt = 0;
   int nfail = 0;

   typedef struct {
      string       tag;
      int          kind;   // 0 data32, 1 ill32, 2 data16, 3 ill16, 4 busy32
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   id_rf_read_unit #(.XLEN(32), .NREG(32), .NRP(2)) dut32 (
      .clk(clk), .rst_n(rst_n), .rst_pipe(rst_pipe), .stall(stall),
      .rs_adr_id(rs_adr_id), .rs_en_id(rs_en_id), .rs_data_ex(d32), .rs_ill_ex(i32),
      .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb), .wbk_data_wb(wbk_data_wb),
      .rf_busy(b32)
   );

   id_rf_read_unit #(.XLEN(32), .NREG(16), .NRP(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .rst_pipe(rst_pipe), .stall(stall),
      .rs_adr_id(rs_adr_id), .rs_en_id(rs_en_id), .rs_data_ex(d16), .rs_ill_ex(i16),
      .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb), .wbk_data_wb(wbk_data_wb),
      .rf_busy(b16)
   );

   function automatic logic [31:0] obs_of(exp_t e);
      case (e.kind)
         0:       return (e.port == 0) ? d32[31:0] : d32[63:32];
         1:       return {31'd0, i32};
         2:       return (e.port == 0) ? d16[31:0] : d16[63:32];
         3:       return {31'd0, i16};
         default: return {31'd0, b32};
      endcase
   endfunction

   task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk($sformatf("%s.k%0d.p%0d", e.tag, e.kind, e.port), obs_of(e), e.exp);
      end
   endtask

   task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic st, input logic rp);
      rs_adr_id     = {a1, a0};
      rs_en_id      = en;
      wbk_rd_reg_wb = we;
      rd_adr_wb     = wa;
      wbk_data_wb   = wd;
      stall         = st;
      rst_pipe      = rp;
   endtask

`ifdef RF_CLEAR_EN
   task automatic count_busy(input string tag, input int exp32, input int exp16);
      int c32 = 0;
      int c16 = 0;
      for (int i = 0; i < 40; i++) begin
         if (b32) c32++;
         if (b16) c16++;
         step();
      end
      chk({tag, ".busy32"}, 32'(c32), 32'(exp32));
      chk({tag, ".busy16"}, 32'(c16), 32'(exp16));
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      drive(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      step();
`ifdef RF_CLEAR_EN
      push("reset", 4, 0, 32'h1);
`else
      push("reset", 4, 0, 32'h0);
`endif
      push("reset", 0, 0, 32'h0);
      push("reset", 0, 1, 32'h0);
      push("reset", 1, 0, 32'h0);
      push("reset", 3, 0, 32'h0);
      step();
      rst_n = 1'b1;

`ifdef RF_CLEAR_EN
      count_busy("sweep", 31, 15);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      count_busy("restart", 31, 15);
      for (int r = 1; r < 32; r++) begin
         drive(5'(r), 5'(r), 2'b11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
         push("clr", 0, 0, 32'h0);
         push("clr", 0, 1, 32'h0);
         step();
      end
`endif

      // Write then read
      drive(5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
      push("t1.wr", 0, 0, 32'h0);
      step();
      drive(5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t1.rd", 0, 0, 32'h1234_5678);
      push("t1.rd", 2, 0, 32'h1234_5678);
      step();

      // Write-first bypass on both ports, and x0
      drive(5'd7, 5'd7, 2'b11, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0);
      push("t2.byp", 0, 0, 32'hDEAD_BEEF);
      push("t2.byp", 0, 1, 32'hDEAD_BEEF);
      step();
      drive(5'd0, 5'd7, 2'b11, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      push("t2.x0byp", 0, 0, 32'h0);
      push("t2.x7arr", 0, 1, 32'hDEAD_BEEF);
      step();
      drive(5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t2.x0rd", 0, 0, 32'h0);
      step();

      // Hold across stall with merge of WB to the held register
      drive(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
      push("t3.wr", 0, 1, 32'h0);
      step();
      drive(5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t3.lat", 0, 1, 32'h11);
      push("t3.lat", 0, 0, 32'h0);
      step();
      drive(5'd0, 5'd4, 2'b10, 1'b1, 5'd4, 32'h99, 1'b1, 1'b0);
      push("t3.st1", 0, 1, 32'h11);
      push("t3.st1", 0, 0, 32'h0);
      step();
      drive(5'd0, 5'd4, 2'b10, 1'b1, 5'd3, 32'h22, 1'b1, 1'b0);
      push("t3.st2", 0, 1, 32'h22);
      push("t3.st2", 0, 0, 32'h0);
      step();
      drive(5'd0, 5'd4, 2'b10, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      push("t3.st3", 0, 1, 32'h22);
      step();
      drive(5'd0, 5'd3, 2'b10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t3.rel", 0, 1, 32'h22);
      step();

      // Out-of-range register on RV32E
      drive(5'd0, 5'd0, 2'b00, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
      step();
      drive(5'd17, 5'd0, 2'b01, 1'b1, 5'd17, 32'hAAAA, 1'b0, 1'b0);
      push("t4.byp", 0, 0, 32'hAAAA);
      push("t4.byp", 1, 0, 32'h0);
      push("t4.byp", 2, 0, 32'h0);
      push("t4.byp", 3, 0, 32'h1);
      step();
      drive(5'd17, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t4.rd", 0, 0, 32'hAAAA);
      push("t4.rd", 2, 0, 32'h0);
      push("t4.rd", 3, 0, 32'h1);
      step();
      drive(5'd17, 5'd0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      push("t4.illhold", 3, 0, 32'h1);
      push("t4.illhold", 0, 0, 32'hAAAA);
      step();
      drive(5'd1, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t4.x1", 2, 0, 32'h1);
      push("t4.x1", 3, 0, 32'h0);
      push("t4.x1", 0, 0, 32'h1);
      step();

      // Pipeline flush during stall, array preserved
      drive(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 32'h55, 1'b0, 1'b0);
      step();
      drive(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t5.lat", 0, 0, 32'h55);
      step();
      drive(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
      push("t5.flush", 0, 0, 32'h0);
      push("t5.flush", 1, 0, 32'h0);
      step();
      drive(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      push("t5.hold", 0, 0, 32'h0);
      step();
      drive(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      push("t5.reread", 0, 0, 32'h55);
      push("t5.reread", 2, 0, 32'h55);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
